// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: video fetch port, CPU port and RAM port.
// Signal names follow the arbiter's external pin list; the arbiter uses the slave modport.
interface vram_arbiter_if #(
  parameter int AW = 15
);
  // Every request is a one-cycle pulse with no ready/backpressure: vid_req is always
  // served, cpu_rd is taken only while cpu_busy is low, and cpu_wr only while wr_full is low.
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_data;
  logic          vid_valid;
  logic          cpu_wr;
  logic          cpu_rd;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_rd_valid;
  logic          cpu_busy;
  logic          wr_full;
  logic          wr_ovf;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout;

  modport slave (
    input  vid_req, vid_addr, cpu_wr, cpu_rd, cpu_addr, cpu_din, ram_dout,
    output vid_data, vid_valid, cpu_dout, cpu_rd_valid, cpu_busy, wr_full, wr_ovf,
           ram_addr, ram_din, ram_we
  );

  modport master (
    output vid_req, vid_addr, cpu_wr, cpu_rd, cpu_addr, cpu_din, ram_dout,
    input  vid_data, vid_valid, cpu_dout, cpu_rd_valid, cpu_busy, wr_full, wr_ovf,
           ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has absolute priority, CPU writes are posted
// through a small FIFO and CPU reads are forwarded from it on an address hit.
module vram_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 15
) (
  input  logic       clk_sys,
  input  logic       nRESET,
  vram_arbiter_if.slave bus,
  output logic [1:0] dbg_grant_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_VID  = 2'd1,
    G_RD   = 2'd2,
    G_WR   = 2'd3
  } grant_t;

  grant_t        g_q, g_d;
  logic [AW-1:0] fifo_addr_q [DEPTH];
  logic [7:0]    fifo_data_q [DEPTH];
  logic [PW-1:0] head_q, tail, idx;
  logic [PW:0]   count_q, count_d;
  logic          rd_pend_q, busy_q, vid_pipe_q, rd_pipe_q;
  logic [AW-1:0] rd_addr_q, rd_addr_cur, ram_addr_q;
  logic [7:0]    ram_din_q, vid_data_q, cpu_dout_q, hit_data;
  logic          vid_valid_q, cpu_rd_valid_q, wr_full_q, wr_ovf_q;
  logic          fifo_full, push, pop, rd_acc, hit, miss_acc, rd_want;

  assign fifo_full   = (count_q == FULL_CNT);
  assign push        = bus.cpu_wr && !fifo_full;
  assign pop         = (g_d == G_WR);
  assign tail        = head_q + count_q[PW-1:0];
  assign rd_acc      = bus.cpu_rd && !busy_q;
  assign miss_acc    = rd_acc && !hit;
  assign rd_want     = rd_pend_q || miss_acc;
  assign rd_addr_cur = rd_pend_q ? rd_addr_q : bus.cpu_addr;
  assign count_d     = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  // Newest match wins. The write currently on the RAM bus is oldest, since a read
  // granted now would race it at the same RAM edge.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    if (g_q == G_WR && ram_addr_q == bus.cpu_addr) begin
      hit      = 1'b1;
      hit_data = ram_din_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((PW+1)'(i) < count_q && fifo_addr_q[idx] == bus.cpu_addr) begin
        hit      = 1'b1;
        hit_data = fifo_data_q[idx];
      end
    end
    if (push && bus.cpu_addr == bus.cpu_addr && bus.cpu_rd) begin
      hit      = 1'b1;
      hit_data = bus.cpu_din;
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) g_q <= G_IDLE;
    else         g_q <= g_d;
  end

  always_comb begin
    g_d = G_IDLE;
    if (bus.vid_req)      g_d = G_VID;
    else if (fifo_full)   g_d = G_WR;
    else if (rd_want)     g_d = G_RD;
    else if (count_q != 0) g_d = G_WR;
  end

  always_comb begin
    bus.ram_we   = (g_q == G_WR);
    bus.ram_addr = ram_addr_q;
    bus.ram_din  = ram_din_q;
    dbg_grant_o  = g_q;
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr_q[tail] <= bus.cpu_addr;
      fifo_data_q[tail] <= bus.cpu_din;
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      head_q         <= '0;
      count_q        <= '0;
      rd_pend_q      <= 1'b0;
      rd_addr_q      <= '0;
      busy_q         <= 1'b0;
      vid_pipe_q     <= 1'b0;
      rd_pipe_q      <= 1'b0;
      ram_addr_q     <= '0;
      ram_din_q      <= '0;
      vid_valid_q    <= 1'b0;
      vid_data_q     <= '0;
      cpu_rd_valid_q <= 1'b0;
      cpu_dout_q     <= '0;
      wr_full_q      <= 1'b0;
      wr_ovf_q       <= 1'b0;
    end else begin
      count_q   <= count_d;
      rd_pend_q <= rd_want && (g_d != G_RD);
      if (pop) head_q <= head_q + PW'(1);
      if (miss_acc) rd_addr_q <= bus.cpu_addr;
      case (g_d)
        G_VID: ram_addr_q <= bus.vid_addr;
        G_RD:  ram_addr_q <= rd_addr_cur;
        G_WR: begin
          ram_addr_q <= fifo_addr_q[head_q];
          ram_din_q  <= fifo_data_q[head_q];
        end
        default: ;
      endcase
      // RAM returns data one edge after the grant cycle; capture it one edge later.
      vid_pipe_q  <= (g_q == G_VID);
      rd_pipe_q   <= (g_q == G_RD);
      vid_valid_q <= vid_pipe_q;
      if (vid_pipe_q) vid_data_q <= bus.ram_dout;
      cpu_rd_valid_q <= rd_pipe_q || (rd_acc && hit);
      if (rd_pipe_q)          cpu_dout_q <= bus.ram_dout;
      else if (rd_acc && hit) cpu_dout_q <= hit_data;
      if (miss_acc)       busy_q <= 1'b1;
      else if (rd_pipe_q) busy_q <= 1'b0;
      wr_full_q <= (count_d == FULL_CNT);
      if (bus.cpu_wr && fifo_full) wr_ovf_q <= 1'b1;
    end
  end

  assign bus.vid_data     = vid_data_q;
  assign bus.vid_valid    = vid_valid_q;
  assign bus.cpu_dout     = cpu_dout_q;
  assign bus.cpu_rd_valid = cpu_rd_valid_q;
  assign bus.cpu_busy     = busy_q;
  assign bus.wr_full      = wr_full_q;
  assign bus.wr_ovf       = wr_ovf_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: video latency, write drain, forwarding, overflow,
// read priority and asynchronous reset, against a behavioural synchronous RAM.
module tb_vram_arbiter;
  localparam int AW = 15;

  logic       clk_sys;
  logic       nRESET;
  logic [1:0] dbg_grant;
  logic       pre_we;
  logic [AW-1:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] mem [2**AW];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int rdv_cnt  = 0;
  int rdg_cnt  = 0;
  int we0, rdv0, rdg0;
  logic [AW+7:0] wr_log [$];
  logic [AW+7:0] exp_q [$];

  vram_arbiter_if #(.AW(AW)) bus ();

  vram_arbiter #(.DEPTH(4), .AW(AW)) dut (
    .clk_sys     (clk_sys),
    .nRESET      (nRESET),
    .bus         (bus),
    .dbg_grant_o (dbg_grant)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Synchronous RAM, read-first, with a back door for preloading.
  always @(posedge clk_sys) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  always @(posedge clk_sys) begin
    if (bus.ram_we) begin
      we_cnt++;
      wr_log.push_back({bus.ram_addr, bus.ram_din});
    end
    if (bus.cpu_rd_valid) rdv_cnt++;
    if (dbg_grant == 2'd2) rdg_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
    bus.cpu_wr   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    tick();
    bus.cpu_wr   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_vid_valid"}, 32'(bus.vid_valid), 32'd0);
    check({tag, "_rd_valid"},  32'(bus.cpu_rd_valid), 32'd0);
    check({tag, "_busy"},      32'(bus.cpu_busy), 32'd0);
    check({tag, "_full"},      32'(bus.wr_full), 32'd0);
    check({tag, "_ovf"},       32'(bus.wr_ovf), 32'd0);
    check({tag, "_ram_we"},    32'(bus.ram_we), 32'd0);
    check({tag, "_ram_addr"},  32'(bus.ram_addr), 32'd0);
    check({tag, "_ram_din"},   32'(bus.ram_din), 32'd0);
    check({tag, "_vid_data"},  32'(bus.vid_data), 32'd0);
    check({tag, "_cpu_dout"},  32'(bus.cpu_dout), 32'd0);
    check({tag, "_grant"},     32'(dbg_grant), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nRESET       = 1'b0;
    pre_we       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;
    bus.vid_req  = 1'b0;
    bus.vid_addr = '0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_rd   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;

    preload(15'h1800, 8'h5A);
    preload(15'h0100, 8'h77);
    for (int i = 0; i < 8; i++) preload(15'h4000 + 15'(i), 8'h00);
    for (int i = 0; i < 8; i++) preload(15'h4010 + 15'(i), 8'h00);
    check_reset_values("rst");
    nRESET = 1'b1;
    tick();

    // Video only: request every 4 cycles, data exactly 2 edges later.
    we0 = we_cnt;
    for (int k = 0; k < 3; k++) begin
      bus.vid_req  = 1'b1;
      bus.vid_addr = 15'h1800;
      tick();
      bus.vid_req  = 1'b0;
      check("vid_grant", 32'(dbg_grant), 32'd1);
      check("vid_valid_e0", 32'(bus.vid_valid), 32'd0);
      tick();
      check("vid_valid_e1", 32'(bus.vid_valid), 32'd0);
      tick();
      check("vid_valid_e2", 32'(bus.vid_valid), 32'd1);
      check("vid_data_e2", 32'(bus.vid_data), 32'h5A);
      tick();
      check("vid_valid_e3", 32'(bus.vid_valid), 32'd0);
    end
    check("vid_no_we", 32'(we_cnt - we0), 32'd0);

    // Write then drain behind continuous video.
    bus.vid_req  = 1'b1;
    bus.vid_addr = 15'h1800;
    we0 = we_cnt;
    cpu_write(15'h4000, 8'h11);
    cpu_write(15'h4001, 8'h22);
    cpu_write(15'h4002, 8'h33);
    tick();
    check("wd_no_we", 32'(we_cnt - we0), 32'd0);
    check("wd_not_full", 32'(bus.wr_full), 32'd0);
    bus.vid_req = 1'b0;
    exp_q.push_back({15'h4000, 8'h11});
    exp_q.push_back({15'h4001, 8'h22});
    exp_q.push_back({15'h4002, 8'h33});
    tick();
    check("wd0_grant", 32'(dbg_grant), 32'd3);
    check("wd0_addr", 32'(bus.ram_addr), 32'h4000);
    check("wd0_din", 32'(bus.ram_din), 32'h11);
    tick();
    check("wd1_addr", 32'(bus.ram_addr), 32'h4001);
    check("wd1_din", 32'(bus.ram_din), 32'h22);
    tick();
    check("wd2_addr", 32'(bus.ram_addr), 32'h4002);
    check("wd2_we", 32'(bus.ram_we), 32'd1);
    tick();
    check("wd_idle_we", 32'(bus.ram_we), 32'd0);
    check("wd_idle_addr", 32'(bus.ram_addr), 32'h4002);
    tick();
    check("wd_mem0", 32'(mem[15'h4000]), 32'h11);
    check("wd_mem1", 32'(mem[15'h4001]), 32'h22);
    check("wd_mem2", 32'(mem[15'h4002]), 32'h33);

    // Forwarding from the FIFO, including a same-cycle write.
    rdg0 = rdg_cnt;
    bus.vid_req = 1'b1;
    cpu_write(15'h4000, 8'hAA);
    cpu_write(15'h4000, 8'hBB);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 15'h4000;
    tick();
    check("fw_valid", 32'(bus.cpu_rd_valid), 32'd1);
    check("fw_dout", 32'(bus.cpu_dout), 32'hBB);
    check("fw_busy", 32'(bus.cpu_busy), 32'd0);
    bus.cpu_wr   = 1'b1;
    bus.cpu_addr = 15'h4005;
    bus.cpu_din  = 8'hC3;
    tick();
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
    check("fw_same_valid", 32'(bus.cpu_rd_valid), 32'd1);
    check("fw_same_dout", 32'(bus.cpu_dout), 32'hC3);
    tick();
    check("fw_valid_end", 32'(bus.cpu_rd_valid), 32'd0);
    bus.vid_req = 1'b0;
    exp_q.push_back({15'h4000, 8'hAA});
    exp_q.push_back({15'h4000, 8'hBB});
    exp_q.push_back({15'h4005, 8'hC3});
    for (int i = 0; i < 5; i++) tick();
    check("fw_no_rd_grant", 32'(rdg_cnt - rdg0), 32'd0);
    check("fw_mem", 32'(mem[15'h4000]), 32'hBB);

    // Overflow: fifth write dropped while video blocks the drain.
    bus.vid_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_write(15'h4010 + 15'(i), 8'(i + 1));
      if (i == 2) check("ov_full_at3", 32'(bus.wr_full), 32'd0);
    end
    check("ov_full_at4", 32'(bus.wr_full), 32'd1);
    check("ov_ovf_at4", 32'(bus.wr_ovf), 32'd0);
    cpu_write(15'h4014, 8'h05);
    check("ov_ovf", 32'(bus.wr_ovf), 32'd1);
    check("ov_full_5", 32'(bus.wr_full), 32'd1);
    bus.vid_req = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({15'h4010 + 15'(i), 8'(i + 1)});
    tick();
    check("ov_full_drop", 32'(bus.wr_full), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("ov_mem3", 32'(mem[15'h4013]), 32'h04);
    check("ov_mem4", 32'(mem[15'h4014]), 32'h00);
    check("ov_sticky", 32'(bus.wr_ovf), 32'd1);

    // Read miss coincident with video: VID first, data 3 edges after acceptance.
    bus.vid_req  = 1'b1;
    bus.vid_addr = 15'h1800;
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 15'h0100;
    tick();
    bus.vid_req = 1'b0;
    bus.cpu_rd  = 1'b0;
    check("pr_a0_grant", 32'(dbg_grant), 32'd1);
    check("pr_a0_busy", 32'(bus.cpu_busy), 32'd1);
    tick();
    check("pr_a1_grant", 32'(dbg_grant), 32'd2);
    check("pr_a1_busy", 32'(bus.cpu_busy), 32'd1);
    check("pr_a1_valid", 32'(bus.cpu_rd_valid), 32'd0);
    tick();
    check("pr_a2_busy", 32'(bus.cpu_busy), 32'd1);
    check("pr_a2_valid", 32'(bus.cpu_rd_valid), 32'd0);
    check("pr_a2_vid", 32'(bus.vid_valid), 32'd1);
    tick();
    check("pr_a3_valid", 32'(bus.cpu_rd_valid), 32'd1);
    check("pr_a3_dout", 32'(bus.cpu_dout), 32'h77);
    check("pr_a3_busy", 32'(bus.cpu_busy), 32'd0);

    // Unobstructed miss: 2 edges.
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 15'h1800;
    tick();
    bus.cpu_rd = 1'b0;
    check("ms_a0_grant", 32'(dbg_grant), 32'd2);
    tick();
    check("ms_a1_valid", 32'(bus.cpu_rd_valid), 32'd0);
    tick();
    check("ms_a2_valid", 32'(bus.cpu_rd_valid), 32'd1);
    check("ms_a2_dout", 32'(bus.cpu_dout), 32'h5A);

    // Reset mid-operation.
    bus.vid_req = 1'b1;
    cpu_write(15'h4020, 8'hE1);
    cpu_write(15'h4021, 8'hE2);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 15'h0100;
    tick();
    bus.cpu_rd = 1'b0;
    check("rm_busy", 32'(bus.cpu_busy), 32'd1);
    #2;
    nRESET = 1'b0;
    #1;
    check_reset_values("rm");
    bus.vid_req = 1'b0;
    tick();
    tick();
    nRESET = 1'b1;
    we0  = we_cnt;
    rdv0 = rdv_cnt;
    for (int i = 0; i < 8; i++) tick();
    check("rm_no_we", 32'(we_cnt - we0), 32'd0);
    check("rm_no_rdv", 32'(rdv_cnt - rdv0), 32'd0);

    // Scoreboard: every RAM write, in order.
    check("sb_len", 32'(wr_log.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      check("sb_write", 32'(wr_log.pop_front()), 32'(exp_q.pop_front()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
